// File: rtl/video_bus_sequencer.sv
// Mac Plus/SE raster timing and shared-RAM slot schedule for the data controller.
// Define VBS_SOUND_FETCH_EN to allocate the per-line sound-buffer fetch slot.
module video_bus_sequencer #(
    parameter int H_TOTAL  = 352,
    parameter int V_TOTAL  = 370,
    parameter int V_ACTIVE = 342
) (
    input  logic        clk32,
    input  logic        _systemReset,
    input  logic        clk8_en_p,
    input  logic        clk8_en_n,
    input  logic        vid_alt,
    input  logic        snd_alt,
    output logic        videoBusControl,
    output logic        cpuBusControl,
    output logic        memoryLatch,
    output logic        loadPixels,
    output logic        loadSound,
    output logic        _hblank,
    output logic        _vblank,
    output logic [20:0] videoAddr
);
    localparam logic [8:0]  H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0]  V_ACT    = 9'(V_ACTIVE);
    localparam logic [20:0] VID_MAIN = 21'h1FD380;
    localparam logic [20:0] VID_ALT  = 21'h1F9380;
    localparam logic [20:0] SND_MAIN = 21'h1FFE80;
    localparam logic [20:0] SND_ALT  = 21'h1FD080;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t      state, state_nx;
    logic [8:0]  hcount, vcount, hc_nx, vc_nx;
    logic        frame_wrap;
    logic        vid_alt_l, snd_alt_l, pix_pend;
    logic        vid_slot, snd_slot, fetch_slot, pix_slot;
    logic [20:0] vid_base, snd_base, addr_nx;

    // Leaving reset, the first enable enters line 0 slot 0 without advancing
    always_comb begin
        state_nx   = state;
        hc_nx      = hcount;
        vc_nx      = vcount;
        frame_wrap = 1'b0;
        case (state)
            ST_IDLE: state_nx = ST_RUN;
            ST_RUN: begin
                if (hcount == H_LAST) begin
                    hc_nx = '0;
                    if (vcount == V_LAST) begin
                        vc_nx      = '0;
                        frame_wrap = 1'b1;
                    end else begin
                        vc_nx = vcount + 9'd1;
                    end
                end else begin
                    hc_nx = hcount + 9'd1;
                end
            end
        endcase
    end

    // Slot decode works on the position that takes effect at this enable
    always_comb begin
        vid_slot = (vc_nx < V_ACT) && !hc_nx[8] && !hc_nx[2];
        pix_slot = (vc_nx < V_ACT) && !hc_nx[8] && hc_nx[2] && (hc_nx[1:0] == 2'd0);
`ifdef VBS_SOUND_FETCH_EN
        snd_slot = (hc_nx[8:2] == 7'd66);
`else
        snd_slot = 1'b0;
`endif
        fetch_slot = vid_slot | snd_slot;
        vid_base   = (frame_wrap ? vid_alt : vid_alt_l) ? VID_MAIN : VID_ALT;
        snd_base   = snd_alt_l ? SND_ALT : SND_MAIN;
        if (vid_slot)
            addr_nx = vid_base + {7'd0, vc_nx, 5'd0} + {16'd0, hc_nx[7:3]};
        else
            addr_nx = snd_base + {12'd0, vc_nx};
    end

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            state           <= ST_IDLE;
            hcount          <= '0;
            vcount          <= '0;
            vid_alt_l       <= 1'b1;
            videoBusControl <= 1'b0;
            cpuBusControl   <= 1'b1;
            loadSound       <= 1'b0;
            _hblank         <= 1'b1;
            _vblank         <= 1'b1;
            videoAddr       <= VID_MAIN;
        end else if (clk8_en_p) begin
            state           <= state_nx;
            hcount          <= hc_nx;
            vcount          <= vc_nx;
            if (frame_wrap)
                vid_alt_l <= vid_alt;
            videoBusControl <= fetch_slot;
            cpuBusControl   <= ~fetch_slot;
            loadSound       <= snd_slot && (hc_nx[1:0] == 2'd3);
            _hblank         <= !hc_nx[8];
            _vblank         <= (vc_nx < V_ACT);
            if (fetch_slot && (hc_nx[1:0] == 2'd0))
                videoAddr <= addr_nx;
        end
    end

    // Single-cycle strobes; pixel load waits for the falling-phase enable
    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            memoryLatch <= 1'b0;
            loadPixels  <= 1'b0;
            pix_pend    <= 1'b0;
        end else begin
            memoryLatch <= clk8_en_p && (hc_nx[1:0] == 2'd3);
            loadPixels  <= clk8_en_n && pix_pend;
            if (clk8_en_p && pix_slot)
                pix_pend <= 1'b1;
            else if (clk8_en_n)
                pix_pend <= 1'b0;
        end
    end

`ifdef VBS_SOUND_FETCH_EN
    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset)
            snd_alt_l <= 1'b0;
        else if (clk8_en_p && (hc_nx == 9'd0))
            snd_alt_l <= snd_alt;
    end
`else
    logic unused_snd_alt;
    assign unused_snd_alt = snd_alt;
    assign snd_alt_l      = 1'b0;
`endif

endmodule

// File: tb/tb_video_bus_sequencer.sv
// Bench for video_bus_sequencer: table checkpoints, hand sequences and a per-cycle reference model.
`timescale 1ns/1ps
module tb_video_bus_sequencer;
    localparam int H  = 352;
    localparam int V  = 8;
    localparam int VA = 5;
    localparam int F  = H * V;
`ifdef VBS_SOUND_FETCH_EN
    localparam bit SND = 1'b1;
`else
    localparam bit SND = 1'b0;
`endif
    localparam logic [20:0] VID_MAIN = 21'h1FD380;
    localparam logic [20:0] VID_ALT  = 21'h1F9380;
    localparam logic [20:0] SND_MAIN = 21'h1FFE80;
    localparam logic [20:0] SND_ALT  = 21'h1FD080;

    logic        clk32 = 1'b0;
    logic        _systemReset = 1'b0;
    logic        clk8_en_p = 1'b0;
    logic        clk8_en_n = 1'b0;
    logic        vid_alt = 1'b1;
    logic        snd_alt = 1'b0;
    logic        videoBusControl, cpuBusControl, memoryLatch, loadPixels, loadSound;
    logic        _hblank, _vblank;
    logic [20:0] videoAddr;

    int checks = 0;
    int errors = 0;
    int mdl_pos = -1;
    int vb_period = -1;
    bit stall_mode = 1'b0;

    video_bus_sequencer #(.H_TOTAL(H), .V_TOTAL(V), .V_ACTIVE(VA)) dut (
        .clk32(clk32), ._systemReset(_systemReset), .clk8_en_p(clk8_en_p), .clk8_en_n(clk8_en_n),
        .vid_alt(vid_alt), .snd_alt(snd_alt), .videoBusControl(videoBusControl),
        .cpuBusControl(cpuBusControl), .memoryLatch(memoryLatch), .loadPixels(loadPixels),
        .loadSound(loadSound), ._hblank(_hblank), ._vblank(_vblank), .videoAddr(videoAddr)
    );

    initial forever #15 clk32 = ~clk32;

    // clk8 enables: rising phase every 4th clk32, falling phase two cycles later
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk32);
            div = (div + 1) % 4;
            clk8_en_p = (div == 0) && !(stall_mode && ($urandom_range(0, 5) == 0));
            clk8_en_n = (div == 2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: position counted in clk8 enables since release, decoded arithmetically
    initial begin
        bit p, n, va, sa;
        int h, v, prints;
        bit vid, snd, m_vbc, m_hb, m_vb, m_ls, m_ml, m_lp, vsel, ssel, pend;
        logic [20:0] m_addr;
        logic [27:0] exp_vec, act_vec;
        prints = 0;
        m_vbc = 0; m_hb = 1; m_vb = 1; m_ls = 0; m_addr = VID_MAIN;
        vsel = 1; ssel = 0; pend = 0;
        forever begin
            @(posedge clk32);
            p = clk8_en_p; n = clk8_en_n; va = vid_alt; sa = snd_alt;
            m_ml = 0; m_lp = 0;
            if (!_systemReset) begin
                mdl_pos = -1;
                m_vbc = 0; m_hb = 1; m_vb = 1; m_ls = 0; m_addr = VID_MAIN;
                vsel = 1; ssel = 0; pend = 0;
            end else begin
                if (n) begin
                    m_lp = pend;
                    pend = 0;
                end
                if (p) begin
                    mdl_pos++;
                    h = mdl_pos % H;
                    v = (mdl_pos / H) % V;
                    if (mdl_pos > 0 && h == 0 && v == 0) vsel = va;
                    if (SND && h == 0) ssel = sa;
                    vid   = (v < VA) && (h < 256) && ((h % 8) < 4);
                    snd   = SND && (h >= 264) && (h < 268);
                    m_vbc = vid || snd;
                    m_hb  = (h < 256);
                    m_vb  = (v < VA);
                    m_ls  = snd && (h % 4 == 3);
                    m_ml  = (h % 4 == 3);
                    if (vid && (h % 8 == 0)) m_addr = (vsel ? VID_MAIN : VID_ALT) + 21'(v * 32 + h / 8);
                    if (snd && h == 264) m_addr = (ssel ? SND_ALT : SND_MAIN) + 21'(v);
                    if ((v < VA) && (h < 256) && (h % 8 == 4)) pend = 1;
                end
            end
            #1;
            exp_vec = {m_vbc, !m_vbc, m_ml, m_lp, m_ls, m_hb, m_vb, m_addr};
            act_vec = {videoBusControl, cpuBusControl, memoryLatch, loadPixels, loadSound,
                       _hblank, _vblank, videoAddr};
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                if (prints < 10) begin
                    prints++;
                    $display("FAIL model pos=%0d: got 0x%07h, expected 0x%07h", mdl_pos, act_vec, exp_vec);
                end
            end
        end
    end

    // Vertical blank period, in clk8 enables between consecutive falling edges
    initial begin
        bit prev, seen, pe;
        int cnt;
        prev = 1; seen = 0; cnt = 0;
        forever begin
            @(posedge clk32);
            pe = clk8_en_p;
            #3;
            if (seen && pe) cnt++;
            if (prev && !_vblank && _systemReset) begin
                if (seen && vb_period < 0) vb_period = cnt;
                seen = 1;
                cnt  = 0;
            end
            prev = _vblank;
        end
    end

    task automatic wait_pos(input int target, input string tag);
        int guard;
        guard = 0;
        do begin
            @(posedge clk32);
            #2;
            guard++;
        end while (mdl_pos != target && guard < 40000);
        if (guard >= 40000) begin
            checks++;
            errors++;
            $display("FAIL wait %s: position %0d, required %0d", tag, mdl_pos, target);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".vbc"}, 32'(videoBusControl), 32'd0);
        check({tag, ".cpu"}, 32'(cpuBusControl), 32'd1);
        check({tag, ".ml"},  32'(memoryLatch), 32'd0);
        check({tag, ".lp"},  32'(loadPixels), 32'd0);
        check({tag, ".ls"},  32'(loadSound), 32'd0);
        check({tag, ".hb"},  32'(_hblank), 32'd1);
        check({tag, ".vb"},  32'(_vblank), 32'd1);
        check({tag, ".addr"}, 32'(videoAddr), 32'(VID_MAIN));
    endtask

    // Line 0 slot 0 after release: four clk8 cycles of video ownership, one latch at phase 3
    task automatic check_slot0(input string tag);
        int guard, vb_cnt, cpu_lo, ml_cnt, ml_at;
        bit hit;
        guard = 0; hit = 0;
        while (!hit && guard < 100) begin
            @(posedge clk32);
            hit = clk8_en_p;
            guard++;
        end
        #2;
        check({tag, ".start"}, 32'(hit), 32'd1);
        check({tag, ".addr"}, 32'(videoAddr), 32'(VID_MAIN));
        vb_cnt = 0; cpu_lo = 0; ml_cnt = 0; ml_at = -1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(posedge clk32);
                #2;
            end
            if (videoBusControl) vb_cnt++;
            if (!cpuBusControl) cpu_lo++;
            if (memoryLatch) begin
                ml_cnt++;
                ml_at = k;
            end
        end
        check({tag, ".vbc_cycles"}, 32'(vb_cnt), 32'd16);
        check({tag, ".cpu_low_cycles"}, 32'(cpu_lo), 32'd16);
        check({tag, ".ml_count"}, 32'(ml_cnt), 32'd1);
        check({tag, ".ml_cycle"}, 32'(ml_at), 32'd12);
    endtask

    // Line 1: 32 video fetches and 32 evenly spaced pixel loads
    task automatic line1_counts();
        int rises, lp, bad, last_lp;
        bit prev;
        logic [20:0] first_a, last_a;
        rises = 0; lp = 0; bad = 0; last_lp = -1; prev = 0;
        first_a = '0; last_a = '0;
        wait_pos(H, "line1");
        for (int k = 0; k < 4 * H; k++) begin
            if (k > 0) begin
                @(posedge clk32);
                #2;
            end
            if (videoBusControl && !prev && _hblank) begin
                rises++;
                if (rises == 1) first_a = videoAddr;
                last_a = videoAddr;
            end
            prev = videoBusControl;
            if (loadPixels) begin
                lp++;
                if (last_lp >= 0 && (k - last_lp) != 32) bad++;
                last_lp = k;
            end
        end
        check("line1.video_slots", 32'(rises), 32'd32);
        check("line1.first_addr", 32'(first_a), 32'h1FD3A0);
        check("line1.last_addr", 32'(last_a), 32'h1FD3BF);
        check("line1.load_pixels", 32'(lp), 32'd32);
        check("line1.lp_spacing_bad", 32'(bad), 32'd0);
    endtask

    typedef struct {
        int          line;
        int          h;
        logic        vbc;
        logic        hb;
        logic        vb;
        logic [20:0] addr;
    } vec_t;

    vec_t tbl[12];

    task automatic run_table();
        for (int i = 0; i < 12; i++) begin
            wait_pos(tbl[i].line * H + tbl[i].h, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.vbc", i),  32'(videoBusControl), 32'(tbl[i].vbc));
            check($sformatf("tbl%0d.cpu", i),  32'(cpuBusControl), 32'(!tbl[i].vbc));
            check($sformatf("tbl%0d.hb", i),   32'(_hblank), 32'(tbl[i].hb));
            check($sformatf("tbl%0d.vb", i),   32'(_vblank), 32'(tbl[i].vb));
            check($sformatf("tbl%0d.addr", i), 32'(videoAddr), 32'(tbl[i].addr));
        end
    endtask

    initial begin
        int ls_cnt, cpu_lo;
        tbl[0]  = '{0, 8,   1'b1, 1'b1, 1'b1, 21'h1FD381};
        tbl[1]  = '{0, 12,  1'b0, 1'b1, 1'b1, 21'h1FD381};
        tbl[2]  = '{0, 256, 1'b0, 1'b0, 1'b1, 21'h1FD39F};
        tbl[3]  = '{0, 264, SND,  1'b0, 1'b1, SND ? 21'h1FFE80 : 21'h1FD39F};
        tbl[4]  = '{1, 0,   1'b1, 1'b1, 1'b1, 21'h1FD3A0};
        tbl[5]  = '{1, 248, 1'b1, 1'b1, 1'b1, 21'h1FD3BF};
        tbl[6]  = '{2, 4,   1'b0, 1'b1, 1'b1, 21'h1FD3C0};
        tbl[7]  = '{4, 351, 1'b0, 1'b0, 1'b1, SND ? 21'h1FFE84 : 21'h1FD41F};
        tbl[8]  = '{5, 0,   1'b0, 1'b1, 1'b0, SND ? 21'h1FFE84 : 21'h1FD41F};
        tbl[9]  = '{6, 264, SND,  1'b0, 1'b0, SND ? 21'h1FFE86 : 21'h1FD41F};
        tbl[10] = '{7, 351, 1'b0, 1'b0, 1'b0, SND ? 21'h1FFE87 : 21'h1FD41F};
        tbl[11] = '{8, 0,   1'b1, 1'b1, 1'b1, 21'h1FD380};

        repeat (3) @(negedge clk32);
        #1;
        check_reset("reset");
        @(negedge clk32);
        _systemReset = 1'b1;
        check_slot0("slot0");

        fork
            run_table();
            line1_counts();
        join

        // Frame 2: switch to alternate buffers mid-frame
        wait_pos(F + 2 * H, "f2.line2");
        vid_alt = 1'b0;
        snd_alt = 1'b1;
        wait_pos(F + 4 * H + 248, "f2.line4");
        check("f2.addr_stays_main", 32'(videoAddr), 32'h1FD41F);
        wait_pos(F + 5 * H + 264, "f2.line5_snd");
        check("f2.snd_addr", 32'(videoAddr), SND ? 32'h1FD085 : 32'h1FD41F);
        ls_cnt = 0; cpu_lo = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(posedge clk32);
                #2;
            end
            if (loadSound) ls_cnt++;
            if (!cpuBusControl) cpu_lo++;
        end
        check("f2.load_sound_cycles", 32'(ls_cnt), SND ? 32'd4 : 32'd0);
        check("f2.snd_cpu_low_cycles", 32'(cpu_lo), SND ? 32'd16 : 32'd0);
        check("vblank_period", 32'(vb_period), 32'(F));

        // Frame 3 picks up the alternate screen base at slot 0
        wait_pos(2 * F, "f3.line0");
        check("f3.alt_addr", 32'(videoAddr), 32'(VID_ALT));
        check("f3.vbc", 32'(videoBusControl), 32'd1);
        vid_alt = 1'b1;
        wait_pos(2 * F + 8, "f3.slot2");
        check("f3.alt_addr_next", 32'(videoAddr), 32'h1F9381);

        // Reset mid-line inside a video slot
        wait_pos(2 * F + 3 * H + 130, "f3.reset_point");
        check("pre_reset.vbc", 32'(videoBusControl), 32'd1);
        @(negedge clk32);
        _systemReset = 1'b0;
        #1;
        check_reset("midreset");
        repeat (2) @(negedge clk32);
        _systemReset = 1'b1;
        check_slot0("slot0_after_reset");

        // Randomised phase: stalled enables and buffer selects toggled at random
        stall_mode = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk32);
            if ($urandom_range(0, 199) == 0) vid_alt = ~vid_alt;
            if ($urandom_range(0, 99) == 0) snd_alt = ~snd_alt;
        end
        stall_mode = 1'b0;
        repeat (8) @(posedge clk32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_bus_sequencer.md
# video_bus_sequencer

Generates Mac Plus/SE raster timing and the shared-RAM time-slot schedule that drive the data controller. The data controller consumes its outputs: `_hblank`, `_vblank`, `memoryLatch`, `loadPixels`, `loadSound`, `videoBusControl` and `cpuBusControl`. The sequencer also produces the word address for every video and sound fetch, which feeds the address mux ahead of RAM. All state advances on `clk8_en_p`; strobes are one `clk32` cycle wide unless stated otherwise.

## Interface
Parameters:
- `H_TOTAL`, 352: clk8 cycles per line (2 pixels per cycle).
- `V_TOTAL`, 370: lines per frame.
- `V_ACTIVE`, 342: visible lines.

Ports:
- `clk32`  in  1  32.5 MHz system clock.
- `_systemReset`  in  1  asynchronous, active-low reset.
- `clk8_en_p`  in  1  clk8 rising-phase enable.
- `clk8_en_n`  in  1  clk8 falling-phase enable; used only for `loadPixels` alignment.
- `vid_alt`  in  1  alternate screen buffer select; 1 = main.
- `snd_alt`  in  1  alternate sound buffer select; 1 = alt.
- `videoBusControl`  out  1  RAM slot owned by video/sound fetch.
- `cpuBusControl`  out  1  RAM slot owned by the CPU.
- `memoryLatch`  out  1  RAM data valid strobe.
- `loadPixels`  out  1  shifter load strobe.
- `loadSound`  out  1  sound sample valid; level signal, one clk8 period.
- `_hblank`  out  1  low during horizontal blank.
- `_vblank`  out  1  low during vertical blank.
- `videoAddr`  out  21  RAM word address, byte address [21:1].

## Operation
- Counters:
  - `hcount` runs 0..H_TOTAL-1 and wraps to 0.
  - `vcount` increments at each `hcount` wrap and runs 0..V_TOTAL-1, wrapping to 0.
- Slots:
  - slot = `hcount[8:2]`, giving 88 four-cycle slots per line.
  - phase = `hcount[1:0]`.
- Video slot: `vcount < V_ACTIVE`, `hcount < 256` and `hcount[2] == 0`. This gives 32 word fetches per line, i.e. 512 pixels.
- Sound slot: `hcount` 264..267 on every line, including blank lines, for 370 samples per frame.
- All other slots belong to the CPU.
- Bus ownership:
  - `videoBusControl` = 1 for all four cycles of a video or sound slot.
  - `cpuBusControl` = ~`videoBusControl` at all times, registered.
- `memoryLatch` pulses in the `clk32` cycle after the `clk8_en_p` at which phase becomes 3, in every slot (CPU slots included).
- `loadPixels` pulses on the first `clk8_en_n` after phase 0 of the slot following each video slot, i.e. every 8 clk8 cycles while active.
- `loadSound` = 1 while phase == 3 of the sound slot.
- Blanking:
  - `_hblank` = 0 iff `hcount >= 256`.
  - `_vblank` = 0 iff `vcount >= V_ACTIVE`.
- Video address: base + `vcount*32` + `hcount[7:3]`.
  - Main base is 0x1FD380 (byte 0x3FA700); alt base is 0x1F9380 (byte 0x3F2700).
- Sound address: base + `vcount`.
  - Main base is 0x1FFE80 (byte 0x3FFD00); alt base is 0x1FD080 (byte 0x3FA100).
- Address update: `videoAddr` updates at phase 0 of each fetch slot and holds until the next fetch slot.
- Address arithmetic: unsigned, 21 bits. No overflow occurs for the legal ranges.
- Buffer-select sampling:
  - `vid_alt` is sampled only when `vcount` wraps to 0; a mid-frame change takes effect at the next frame.
  - `snd_alt` is sampled at `hcount == 0` of every line.

## Timing
- Reset (asynchronous, `_systemReset` = 0) sets:
  - `hcount` = 0, `vcount` = 0;
  - `videoBusControl` = 0, `cpuBusControl` = 1;
  - `memoryLatch`, `loadPixels`, `loadSound` = 0;
  - `_hblank` = 1, `_vblank` = 1;
  - `videoAddr` = 0x1FD380;
  - latched `vid_alt` = 1, latched `snd_alt` = 0.
- Reset mid-operation: outputs take their reset values in the same `clk32` cycle. Timing restarts at line 0, slot 0 on the first `clk8_en_p` after release.
- Frame length: 352 × 370 = 130240 clk8 cycles. Line length: 352 cycles.
- Fetch data latency: data is valid at `memoryLatch`, three clk8 cycles after slot start.
- Simultaneous events: `hcount` and `vcount` wrapping together updates both counters and samples `vid_alt` in the same `clk8_en_p` cycle. Slot 0 of line 0 then uses the newly sampled base.
- With no `clk8_en_p`, all state holds.

## Configuration
- `VBS_SOUND_FETCH_EN` defined: the sound slot is allocated as above.
- `VBS_SOUND_FETCH_EN` undefined:
  - `loadSound` is tied to 0;
  - `hcount` 264..267 is a CPU slot;
  - `snd_alt` is ignored.

## Test plan
- Release reset, run to line 0 slot 0:
  - `videoAddr` = 0x1FD380;
  - `videoBusControl` = 1 for 4 clk8 cycles;
  - one `memoryLatch` pulse at phase 3;
  - `cpuBusControl` = 0 during the slot.
- Count over line 1: exactly 32 video slots; first address 0x1FD3A0, last 0x1FD3BF; `loadPixels` pulses 32 times, spaced 8 clk8 cycles apart.
- Blanking:
  - `_hblank` falls at `hcount` 256 and rises at 0;
  - `_vblank` falls at line 342 start and rises at frame wrap;
  - period = 130240 clk8 cycles.
- Sound fetch on line 5: address 0x1FFE85 with `snd_alt` = 0, and 0x1FD085 with `snd_alt` = 1; `loadSound` high for exactly 1 clk8 period; with the macro undefined, `loadSound` stays 0 and `cpuBusControl` stays 1.
- Drive `vid_alt` = 0 at line 100: addresses stay on the main base through line 341; the next frame's line 0 slot 0 address = 0x1F9380.
- Assert `_systemReset` at line 200, `hcount` 130: all outputs reach their reset values within 1 `clk32` cycle; after release, line 0 slot 0 timing repeats test 1.
